// File: rtl/mario_pkg.sv
// Shared constants and encodings for the stage scanners and the sprite pipeline.
package mario_pkg;

  localparam int COORD_W  = 13;
  localparam int SCREEN_W = 640;
  localparam int BOX_W    = 40;

  typedef enum logic [1:0] {
    COIN  = 2'd0,
    PILZ  = 2'd1,
    BOX   = 2'd2,
    STONE = 2'd3
  } box_state_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_EMIT = 2'd2,
    ST_DONE = 2'd3
  } scan_state_e;

endpackage

// File: rtl/obj_visible_cmp.sv
// Combinational visibility test of one world object against the camera window,
// plus its screen-relative x. Shared by all object scanners.
module obj_visible_cmp
  import mario_pkg::*;
#(
  parameter int CW  = COORD_W,
  parameter int OW  = BOX_W,
  parameter int SW  = SCREEN_W
) (
  input  logic [CW-1:0] x,
  input  logic [CW-1:0] y,
  input  logic [CW-1:0] cam,
  output logic          visible,
  output logic [CW-1:0] screen_x
);

  logic [CW:0] right_edge;
  logic [CW:0] cam_right;
  logic        enabled;

  // One extra bit keeps both sums from wrapping near the top of world space.
  assign right_edge = {1'b0, x} + (CW+1)'(OW);
  assign cam_right  = {1'b0, cam} + (CW+1)'(SW);
  assign enabled    = ({x, y} != '0);

  assign visible  = enabled && (right_edge > {1'b0, cam}) && ({1'b0, x} < cam_right);
  assign screen_x = x - cam;

endmodule

// File: rtl/box_visibility_scanner.sv
// Walks the flat box tables each frame and streams visible boxes to the renderer.
// Optional visible_count output enabled by macro BOX_SCAN_COUNT_EN.
module box_visibility_scanner
  import mario_pkg::*;
#(
  parameter int N_BOX = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [COORD_W-1:0]       camera_x,
  input  logic [COORD_W*N_BOX-1:0] box_x,
  input  logic [COORD_W*N_BOX-1:0] box_y,
  input  logic [2*N_BOX-1:0]       box_state,
  output logic                     obj_valid,
  input  logic                     obj_ready,
  output logic [COORD_W-1:0]       obj_x,
  output logic [COORD_W-1:0]       obj_y,
  output logic [1:0]               obj_state,
  output logic [5:0]               obj_idx,
`ifdef BOX_SCAN_COUNT_EN
  output logic [6:0]               visible_count,
`endif
  output logic                     busy,
  output logic                     done
);

  scan_state_e        state_reg, state_next;
  logic [5:0]         idx_reg;
  logic [COORD_W-1:0] cam_reg;
  logic [COORD_W-1:0] cur_x, cur_y, cur_sx;
  logic [1:0]         cur_s;
  logic               cur_vis;
  logic               last;
  logic               latch_start, advance, load_obj, handshake;

  // Stage buses are static during a frame, so entries are read live.
  assign cur_x = box_x[int'(idx_reg)*COORD_W +: COORD_W];
  assign cur_y = box_y[int'(idx_reg)*COORD_W +: COORD_W];
  assign cur_s = box_state[int'(idx_reg)*2 +: 2];
  assign last  = (idx_reg == 6'(N_BOX-1));

  obj_visible_cmp #(
    .CW (COORD_W),
    .OW (BOX_W),
    .SW (SCREEN_W)
  ) u_cmp (
    .x        (cur_x),
    .y        (cur_y),
    .cam      (cam_reg),
    .visible  (cur_vis),
    .screen_x (cur_sx)
  );

  always_comb begin
    state_next  = state_reg;
    latch_start = 1'b0;
    advance     = 1'b0;
    load_obj    = 1'b0;
    handshake   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          latch_start = 1'b1;
          state_next  = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (cur_vis) begin
          load_obj   = 1'b1;
          state_next = ST_EMIT;
        end else if (last) begin
          state_next = ST_DONE;
        end else begin
          advance = 1'b1;
        end
      end
      ST_EMIT: begin
        if (obj_ready) begin
          handshake = 1'b1;
          if (last) begin
            state_next = ST_DONE;
          end else begin
            advance    = 1'b1;
            state_next = ST_SCAN;
          end
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      idx_reg   <= '0;
      cam_reg   <= '0;
      obj_x     <= '0;
      obj_y     <= '0;
      obj_state <= '0;
      obj_idx   <= '0;
    end else begin
      state_reg <= state_next;
      if (latch_start) begin
        cam_reg <= camera_x;
        idx_reg <= '0;
      end else if (advance) begin
        idx_reg <= idx_reg + 6'd1;
      end
      if (load_obj) begin
        obj_x     <= cur_sx;
        obj_y     <= cur_y;
        obj_state <= cur_s;
        obj_idx   <= idx_reg;
      end
    end
  end

  // Handshake outputs come straight from the state register: no ready-to-valid path.
  assign obj_valid = (state_reg == ST_EMIT);
  assign busy      = (state_reg == ST_SCAN) || (state_reg == ST_EMIT);
  assign done      = (state_reg == ST_DONE);

`ifdef BOX_SCAN_COUNT_EN
  logic [6:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (latch_start) begin
      count_reg <= '0;
    end else if (handshake) begin
      count_reg <= count_reg + 7'd1;
    end
  end

  assign visible_count = count_reg;
`else
  logic unused_handshake;
  assign unused_handshake = handshake;
`endif

endmodule

// File: tb/tb_box_visibility_scanner.sv
// Bench for box_visibility_scanner: directed frames plus random tables against
// an arithmetic model of the visibility rules, with random consumer stalls.
module tb_box_visibility_scanner;

  localparam int NB = 64;
  localparam int CW = 13;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [CW-1:0]    camera_x = '0;
  logic [CW*NB-1:0] box_x = '0;
  logic [CW*NB-1:0] box_y = '0;
  logic [2*NB-1:0]  box_state = '0;
  logic             obj_valid;
  logic             obj_ready = 1'b0;
  logic [CW-1:0]    obj_x, obj_y;
  logic [1:0]       obj_state;
  logic [5:0]       obj_idx;
  logic             busy, done;
`ifdef BOX_SCAN_COUNT_EN
  logic [6:0]       visible_count;
`endif

  box_visibility_scanner #(.N_BOX(NB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .camera_x  (camera_x),
    .box_x     (box_x),
    .box_y     (box_y),
    .box_state (box_state),
    .obj_valid (obj_valid),
    .obj_ready (obj_ready),
    .obj_x     (obj_x),
    .obj_y     (obj_y),
    .obj_state (obj_state),
    .obj_idx   (obj_idx),
`ifdef BOX_SCAN_COUNT_EN
    .visible_count (visible_count),
`endif
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int tab_x [NB];
  int tab_y [NB];
  int tab_s [NB];
  int last_emits = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_tables();
    for (int i = 0; i < NB; i++) begin
      tab_x[i] = 0; tab_y[i] = 0; tab_s[i] = 0;
    end
  endtask

  task automatic load_tables();
    for (int i = 0; i < NB; i++) begin
      box_x[i*CW +: CW]  = CW'(tab_x[i]);
      box_y[i*CW +: CW]  = CW'(tab_y[i]);
      box_state[i*2 +: 2] = 2'(tab_s[i]);
    end
  endtask

  function automatic bit model_visible(input int i, input int cam);
    if (tab_x[i] == 0 && tab_y[i] == 0) return 1'b0;
    return (tab_x[i] + 40 > cam) && (tab_x[i] < cam + 640);
  endfunction

  // One frame: start, consume emissions with stalls, check order, fields, stability and done timing.
  task automatic run_scan(input string name, input int cam, input int first_stall,
                          input int stall_max, input bit inject_start);
    int exp_q[$];
    int k, exp_done, nemit, stall, e;
    bit in_emit, finished;
    for (int i = 0; i < NB; i++) if (model_visible(i, cam)) exp_q.push_back(i);
    load_tables();
    @(negedge clk);
    camera_x = CW'(cam);
    start = 1'b1;
    obj_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    k = 1; exp_done = NB + 1; nemit = 0; stall = 0; in_emit = 0; finished = 0;
    chk({name, " busy_rise"}, 32'(busy), 1);
`ifdef BOX_SCAN_COUNT_EN
    chk({name, " count_clear"}, 32'(visible_count), 0);
`endif
    while (!finished && k < 4000) begin
      if (k == 3) camera_x = CW'($urandom);
      if (inject_start) start = (k == 7);
      if (in_emit && obj_ready) begin
        in_emit = 0;
        obj_ready = 1'b0;
        nemit++;
        chk({name, " valid_drop"}, 32'(obj_valid), 0);
      end
      if (done) begin
        chk({name, " done_cycle"}, k, exp_done);
        chk({name, " done_busy"}, 32'(busy), 0);
        chk({name, " emit_count"}, nemit, exp_q.size());
        finished = 1;
      end else begin
        chk({name, " busy"}, 32'(busy), 1);
        if (obj_valid) begin
          if (!in_emit) begin
            in_emit = 1;
            stall = (nemit == 0 && first_stall >= 0) ? first_stall : int'($urandom_range(stall_max, 0));
            exp_done += 1 + stall;
          end
          if (nemit < exp_q.size()) begin
            e = exp_q[nemit];
            chk({name, " idx"}, 32'(obj_idx), e);
            chk({name, " x"}, 32'(obj_x), (tab_x[e] - cam) & 32'h1FFF);
            chk({name, " y"}, 32'(obj_y), tab_y[e]);
            chk({name, " state"}, 32'(obj_state), tab_s[e]);
          end else begin
            chk({name, " extra_emission"}, 32'(obj_idx), 32'hFFFF_FFFF);
          end
          if (stall == 0) obj_ready = 1'b1;
          else stall--;
        end
      end
      if (!finished) begin
        @(negedge clk);
        k++;
      end
    end
    start = 1'b0;
    if (!finished) chk({name, " timeout"}, k, exp_done);
    last_emits = nemit;
    @(negedge clk);
    chk({name, " done_pulse_len"}, 32'(done), 0);
    chk({name, " idle_busy"}, 32'(busy), 0);
`ifdef BOX_SCAN_COUNT_EN
    repeat (3) @(negedge clk);
    chk({name, " count_hold"}, 32'(visible_count), exp_q.size());
`endif
  endtask

  initial begin
    int cam, lo, hi;
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst valid", 32'(obj_valid), 0);
    chk("rst busy", 32'(busy), 0);
    chk("rst done", 32'(done), 0);
    chk("rst obj_x", 32'(obj_x), 0);
    chk("rst obj_idx", 32'(obj_idx), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic frame: one visible stone, one box beyond the right edge.
    clear_tables();
    tab_x[0] = 320; tab_y[0] = 359; tab_s[0] = 3;
    tab_x[1] = 760; tab_y[1] = 439; tab_s[1] = 2;
    run_scan("basic", 0, 0, 0, 0);
    chk("basic n", last_emits, 1);

    // Left edge: partial box with negative screen x; exact touch is invisible.
    clear_tables();
    tab_x[0] = 280; tab_y[0] = 100; tab_s[0] = 1;
    tab_x[1] = 260; tab_y[1] = 100; tab_s[1] = 2;
    run_scan("left", 300, 0, 0, 0);
    chk("left n", last_emits, 1);

    // Right edge.
    clear_tables();
    tab_x[0] = 640; tab_y[0] = 50; tab_s[0] = 0;
    tab_x[1] = 639; tab_y[1] = 50; tab_s[1] = 3;
    run_scan("right", 0, 0, 0, 0);
    chk("right n", last_emits, 1);

    // Backpressure on the first of two, plus a start while busy.
    clear_tables();
    tab_x[3] = 100; tab_y[3] = 200; tab_s[3] = 2;
    tab_x[5] = 500; tab_y[5] = 210; tab_s[5] = 1;
    run_scan("stall", 0, 5, 2, 1);

    // Empty tables.
    clear_tables();
    run_scan("empty", 0, 0, 0, 0);
    chk("empty n", last_emits, 0);

    // Boxes packed every 40 pixels: only the first 16 land on screen.
    clear_tables();
    for (int i = 0; i < NB; i++) begin
      tab_x[i] = 40 * i; tab_y[i] = 100; tab_s[i] = i % 4;
    end
    run_scan("row", 0, 0, 1, 0);
    chk("row n", last_emits, 16);

    // Abort mid-EMIT of idx 10, then rescan from idx 0.
    clear_tables();
    tab_x[2]  = 10;  tab_y[2]  = 20; tab_s[2]  = 0;
    tab_x[10] = 200; tab_y[10] = 30; tab_s[10] = 3;
    load_tables();
    @(negedge clk);
    camera_x = '0; start = 1'b1; obj_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (obj_valid && obj_idx == 6'd10) break;
      @(negedge clk);
    end
    obj_ready = 1'b0;
    chk("abort reach idx10", 32'(obj_idx), 10);
    #2 rst_n = 1'b0;
    #1;
    chk("abort valid", 32'(obj_valid), 0);
    chk("abort busy", 32'(busy), 0);
    chk("abort done", 32'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("abort no done", 32'(done), 0);
    end
    run_scan("rescan", 0, 0, 0, 0);
    chk("rescan n", last_emits, 2);

    // Random tables around a random camera, random stalls.
    for (int r = 0; r < 6; r++) begin
      cam = int'($urandom_range(7000, 0));
      lo = (cam > 700) ? cam - 700 : 0;
      hi = (cam + 800 > 8191) ? 8191 : cam + 800;
      for (int i = 0; i < NB; i++) begin
        if ($urandom_range(3, 0) == 0) begin
          tab_x[i] = 0; tab_y[i] = 0; tab_s[i] = 0;
        end else begin
          tab_x[i] = int'($urandom_range(hi, lo));
          tab_y[i] = int'($urandom_range(8191, 0));
          tab_s[i] = int'($urandom_range(3, 0));
        end
      end
      run_scan("rand", cam, -1, 3, r[0]);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
